link_frame_receiver: RTL and testbench
======================================

Name: link_frame_receiver

Overview:
- Receiving end of the inter-board link: recovers 12-bit words (keyboard controls or health data) that the partner board sends as nibble frames on an 8-pin Pmod bundle.
- Synchronises the pins into the 100 MHz domain and checks sequence and parity per nibble.
- Publishes the last good word, with a valid pulse, a link-up flag and error statistics.
- Sits between the JXADC pins and the consumers of other_keyboard_data / other_health_data.

Parameters:
- SETTLE_CYCLES, 8: clk cycles waited after a strobe toggle before sampling pins.
- TIMEOUT_CYCLES, 200000: clk cycles without a strobe toggle before link_up drops (2 ms).
- CLEAR_ON_TIMEOUT, 0: 1 = data_out forced to 0 when link drops; 0 = hold last word.

Ports:
- clk, input, 1: 100 MHz system clock.
- rst, input, 1: synchronous active-high reset.
- rx_pins, input, 8: raw asynchronous pins from the partner board.
  - [3:0] nibble payload.
  - [5:4] nibble index: 0 = bits[3:0], 1 = bits[7:4], 2 = bits[11:8].
  - [6] even parity over [5:0].
  - [7] strobe, toggles once per new nibble.
- data_out, output, 12: last complete, error-free word.
- data_valid, output, 1: one-cycle pulse when data_out updates.
- link_up, output, 1: strobe activity seen within TIMEOUT_CYCLES.
- frame_err, output, 1: one-cycle pulse on any parity or sequence error.
- err_count, output, 8: saturating error counter.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high. All outputs are registered.
- Reset values:
  - data_out = 0, data_valid = 0, link_up = 0, frame_err = 0, err_count = 0.
  - FSM = WAIT_EDGE, expected index = 0, timeout counter = 0.
  - Synchroniser flops = 0; the previous-strobe register is loaded from the synchronised strobe on the first post-reset cycle, so no false edge is seen.
- Synchronisation: all 8 pins pass through a 2-flop synchroniser. An edge is detected when sync_strobe differs from the previous-strobe register.
- FSM states:
  - WAIT_EDGE: on an edge, load settle counter with SETTLE_CYCLES-1 and go to SETTLE.
  - SETTLE: decrement. At 0, go to SAMPLE. A new edge during SETTLE restarts the count and does not count as an error.
  - SAMPLE (1 cycle): capture sync [6:0]. Compute parity_ok = XOR of [6:0] == 0. Return to WAIT_EDGE.
- Sample processing, with exp_idx as the expected nibble index:
  - parity_ok and idx == exp_idx: store the nibble in the shadow register slot idx, then advance exp_idx.
    - If idx == 2: copy the shadow word to data_out, pulse data_valid the next cycle, and set exp_idx = 0.
  - parity fail, idx == 3, or idx != exp_idx: pulse frame_err and increment err_count (saturates at 255).
    - Then resynchronise: if idx == 0 and parity_ok, accept the nibble as slot 0 and set exp_idx = 1; otherwise set exp_idx = 0.
- Latency: strobe toggle on the pins to data_valid for the final nibble = 2 (sync) + 1 (edge) + SETTLE_CYCLES + 1 (sample) + 1 (register) clk cycles. That is 13 cycles at default SETTLE_CYCLES.
- Timeout:
  - Counter resets to 0 on every detected edge and sets link_up = 1.
  - Otherwise it increments, saturating at TIMEOUT_CYCLES. On reaching TIMEOUT_CYCLES: link_up = 0, exp_idx = 0, and the partial shadow is discarded.
  - If CLEAR_ON_TIMEOUT = 1, data_out is also cleared; no data_valid pulse is issued for that clear.
- Simultaneous events: an edge and timeout saturation in the same cycle resolve as edge wins (link_up = 1). An error and counter saturation in the same cycle leave err_count at 255.
- Reset mid-frame discards the partial word; the first frame after reset must start at index 0.
- Word width rule: data_out[3:0] = slot 0, [7:4] = slot 1, [11:8] = slot 2. No partial updates are ever visible on data_out.

Decomposition:
- Shared package link_pkg holds the pin field positions (STROBE_BIT = 7, PARITY_BIT = 6, IDX_MSB/LSB = 5/4, NIB_MSB/LSB = 3/0), NIBBLES_PER_WORD = 3, WORD_W = 12 and the FSM state encoding.
- The matching transmitter uses the same package.
- One natural sub-module: pin_sync2, a parameterised-width 2-flop synchroniser with synchronous reset.

Test Plan:
- Send word 12'hA5C as nibbles C, 5, A (idx 0, 1, 2, correct parity, strobe toggling every 2000 cycles) -> data_out = 12'hA5C, a single data_valid pulse 13 cycles after the third toggle, link_up = 1, err_count = 0.
- Corrupt parity on nibble idx 1 of word 12'h123 -> frame_err pulse, err_count = 1, data_out unchanged. The following clean 12'h456 -> data_out = 12'h456.
- Sequence 0, 2 (skip 1) then a clean 0, 1, 2 of 12'h7E1 -> one frame_err; data_out = 12'h7E1 only after the full clean frame.
- Stop the strobe for TIMEOUT_CYCLES+1 with CLEAR_ON_TIMEOUT = 1 after 12'hFFF -> link_up falls exactly at count TIMEOUT_CYCLES and data_out = 0. With CLEAR_ON_TIMEOUT = 0, data_out stays 12'hFFF.
- Assert rst after nibble idx 1 of 12'hBEE, then send 2 alone, then a full 12'h321 -> all outputs 0 during reset, one error for the orphan idx 2, data_out = 12'h321.
- Inject 300 parity errors -> err_count saturates at 255 and does not wrap.

Source files
------------

// File: rtl/link_pkg.sv
// link_pkg: pin field layout, word geometry and receiver FSM encoding for the inter-board link
package link_pkg;
  localparam int STROBE_BIT = 7;
  localparam int PARITY_BIT = 6;
  localparam int IDX_MSB = 5;
  localparam int IDX_LSB = 4;
  localparam int NIB_MSB = 3;
  localparam int NIB_LSB = 0;
  localparam int NIBBLES_PER_WORD = 3;
  localparam int WORD_W = 12;
  typedef enum logic [1:0] {WAIT_EDGE, SETTLE, SAMPLE} rx_state_t;
endpackage

// File: rtl/link_frame_receiver_if.sv
// link_frame_receiver_if: pin bundle from the partner board and the recovered-word outputs
interface link_frame_receiver_if;
  import link_pkg::*;
  logic [7:0] rx_pins;
  logic [WORD_W-1:0] data_out;
  logic data_valid;
  logic link_up;
  logic frame_err;
  logic [7:0] err_count;
  modport master (output rx_pins, input data_out, data_valid, link_up, frame_err, err_count);
  modport slave (input rx_pins, output data_out, data_valid, link_up, frame_err, err_count);
endinterface

// File: rtl/pin_sync2.sv
// pin_sync2: parameterised-width two-flop synchroniser with synchronous reset
module pin_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  // two-stage capture of the asynchronous pins
  always_ff @(posedge clk) begin
    if (rst) begin
      m <= '0;
      q <= '0;
    end else begin
      m <= d;
      q <= m;
    end
  end
endmodule

// File: rtl/link_frame_receiver.sv
// link_frame_receiver: recovers 12-bit words from strobed, parity-protected nibble frames
module link_frame_receiver
  import link_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter bit CLEAR_ON_TIMEOUT = 1'b0
) (
  input logic clk,
  input logic rst,
  link_frame_receiver_if.slave bus
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [7:0] sync;
  logic prev_strobe, cap_vld, edge_det, pok, good;
  logic [2:0] arm;
  logic [6:0] cap;
  logic [1:0] idx, exp_idx;
  logic [3:0] nib;
  logic [7:0] shadow;
  logic [SW-1:0] cnt, cnt_n;
  logic [TW-1:0] tcnt;
  rx_state_t state, state_n;
  pin_sync2 #(.W(8)) u_sync (.clk(clk), .rst(rst), .d(bus.rx_pins), .q(sync));
  // edge detect, settle sequencing and decode of the captured nibble
  always_comb begin
    edge_det = arm[2] && (sync[STROBE_BIT] != prev_strobe);
    state_n = edge_det ? SETTLE : (state == SETTLE && cnt == '0) ? SAMPLE : (state == SAMPLE) ? WAIT_EDGE : state;
    cnt_n = edge_det ? SW'(SETTLE_CYCLES - 1) : (state == SETTLE && cnt != '0) ? cnt - SW'(1) : cnt;
    idx = cap[IDX_MSB:IDX_LSB];
    nib = cap[NIB_MSB:NIB_LSB];
    pok = ~^cap;
    good = pok && idx == exp_idx;
  end
  // FSM state, strobe history and sample capture; arm masks edges until the synchroniser holds real pin data
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_EDGE;
      cnt <= '0;
      arm <= '0;
      prev_strobe <= 1'b0;
      cap <= '0;
      cap_vld <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      arm <= {arm[1:0], 1'b1};
      prev_strobe <= sync[STROBE_BIT];
      cap_vld <= state == SAMPLE;
      if (state == SAMPLE) cap <= sync[PARITY_BIT:0];
    end
  end
  // word assembly, error statistics and link timeout; timeout overrides the sequence tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_idx <= '0;
      shadow <= '0;
      tcnt <= '0;
      bus.data_out <= '0;
      bus.data_valid <= 1'b0;
      bus.link_up <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.err_count <= '0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      if (cap_vld && good) begin
        if (idx == 2'd2) begin
          bus.data_out <= {nib, shadow};
          bus.data_valid <= 1'b1;
          exp_idx <= '0;
        end else begin
          if (idx[0]) shadow[7:4] <= nib;
          else shadow[3:0] <= nib;
          exp_idx <= exp_idx + 2'd1;
        end
      end else if (cap_vld) begin
        bus.frame_err <= 1'b1;
        if (bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
        exp_idx <= (idx == 2'd0 && pok) ? 2'd1 : 2'd0;
        if (idx == 2'd0 && pok) shadow[3:0] <= nib;
      end
      if (edge_det) begin
        tcnt <= '0;
        bus.link_up <= 1'b1;
      end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
        tcnt <= tcnt + TW'(1);
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bus.link_up <= 1'b0;
          exp_idx <= '0;
          shadow <= '0;
          if (CLEAR_ON_TIMEOUT) bus.data_out <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_link_frame_receiver.sv
// tb_link_frame_receiver: directed nibble-frame stimulus with hand-computed expectations
module tb_link_frame_receiver;
  import link_pkg::*;
  localparam int GAP = 20;
  localparam int TMO = 300;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] pins = '0;
  logic strobe = 1'b0;
  int checks = 0;
  int errors = 0;
  int dv_cnt, fe_cnt, dv_at, clr_dv;
  link_frame_receiver_if bus_h ();
  link_frame_receiver_if bus_c ();
  assign bus_h.rx_pins = pins;
  assign bus_c.rx_pins = pins;
  always #5 clk = ~clk;
  link_frame_receiver #(.TIMEOUT_CYCLES(TMO), .CLEAR_ON_TIMEOUT(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus_h));
  link_frame_receiver #(.TIMEOUT_CYCLES(TMO), .CLEAR_ON_TIMEOUT(1'b1)) dut_clr (.clk(clk), .rst(rst), .bus(bus_c));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_counts;
    dv_cnt = 0;
    fe_cnt = 0;
    dv_at = 0;
  endtask
  task automatic send_nibble(input logic [3:0] nib, input logic [1:0] idx, input bit bad = 1'b0);
    logic [5:0] f;
    f = {idx, nib};
    strobe = ~strobe;
    pins = {strobe, (^f) ^ bad, f};
    for (int i = 1; i <= GAP; i++) begin
      tick();
      if (bus_h.data_valid) begin
        dv_cnt++;
        dv_at = i;
      end
      if (bus_h.frame_err) fe_cnt++;
    end
  endtask
  task automatic send_word(input logic [11:0] w);
    send_nibble(w[3:0], 2'd0);
    send_nibble(w[7:4], 2'd1);
    send_nibble(w[11:8], 2'd2);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, bus_h.data_out, 0);
    check({tag, "_dv"}, bus_h.data_valid, 0);
    check({tag, "_link"}, bus_h.link_up, 0);
    check({tag, "_ferr"}, bus_h.frame_err, 0);
    check({tag, "_errc"}, bus_h.err_count, 0);
  endtask
  initial begin
    repeat (4) tick();
    check_reset_outputs("rst0");
    rst = 1'b0;
    repeat (5) tick();
    clear_counts();
    send_word(12'hA5C);
    check("a5c_data", bus_h.data_out, 12'hA5C);
    check("a5c_dv_cnt", dv_cnt, 1);
    check("a5c_latency", dv_at, 13);
    check("a5c_link", bus_h.link_up, 1);
    check("a5c_errc", bus_h.err_count, 0);
    check("a5c_ferr", fe_cnt, 0);
    clear_counts();
    send_nibble(4'h3, 2'd0);
    send_nibble(4'h2, 2'd1, 1'b1);
    check("par_ferr", fe_cnt, 1);
    check("par_errc", bus_h.err_count, 1);
    check("par_data", bus_h.data_out, 12'hA5C);
    check("par_dv", dv_cnt, 0);
    clear_counts();
    send_word(12'h456);
    check("456_data", bus_h.data_out, 12'h456);
    check("456_dv", dv_cnt, 1);
    clear_counts();
    send_nibble(4'h1, 2'd0);
    send_nibble(4'h7, 2'd2);
    check("skip_ferr", fe_cnt, 1);
    check("skip_errc", bus_h.err_count, 2);
    check("skip_data", bus_h.data_out, 12'h456);
    send_nibble(4'h1, 2'd0);
    send_nibble(4'hE, 2'd1);
    check("7e1_partial", bus_h.data_out, 12'h456);
    send_nibble(4'h7, 2'd2);
    check("7e1_data", bus_h.data_out, 12'h7E1);
    check("7e1_dv", dv_cnt, 1);
    check("7e1_ferr", fe_cnt, 1);
    check("7e1_errc", bus_h.err_count, 2);
    send_word(12'hFFF);
    check("fff_hold", bus_h.data_out, 12'hFFF);
    check("fff_clr", bus_c.data_out, 12'hFFF);
    clr_dv = 0;
    for (int i = GAP + 1; i <= TMO + 3; i++) begin
      tick();
      if (bus_c.data_valid) clr_dv++;
      if (i == TMO + 2) begin
        check("tmo_link_before", bus_h.link_up, 1);
        check("tmo_link_before_c", bus_c.link_up, 1);
      end
    end
    check("tmo_link_h", bus_h.link_up, 0);
    check("tmo_link_c", bus_c.link_up, 0);
    check("tmo_hold_data", bus_h.data_out, 12'hFFF);
    check("tmo_clr_data", bus_c.data_out, 0);
    check("tmo_clr_no_dv", clr_dv, 0);
    send_nibble(4'hE, 2'd0);
    send_nibble(4'hE, 2'd1);
    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst1");
    rst = 1'b0;
    repeat (5) tick();
    clear_counts();
    send_nibble(4'hB, 2'd2);
    check("orphan_ferr", fe_cnt, 1);
    check("orphan_errc", bus_h.err_count, 1);
    check("orphan_data", bus_h.data_out, 0);
    check("orphan_dv", dv_cnt, 0);
    clear_counts();
    send_word(12'h321);
    check("321_data", bus_h.data_out, 12'h321);
    check("321_dv", dv_cnt, 1);
    check("321_errc", bus_h.err_count, 1);
    clear_counts();
    for (int k = 1; k <= 300; k++) begin
      send_nibble(4'h0, 2'd0, 1'b1);
      if (k == 100) check("sat_mid", bus_h.err_count, 101);
    end
    check("sat_errc", bus_h.err_count, 255);
    check("sat_ferr_cnt", fe_cnt, 300);
    check("sat_data", bus_h.data_out, 12'h321);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
